// File: rtl/rv32v_vreg_readback_if.sv
// rv32v_vreg_readback_if -- request, register-file read and output stream
// bundle for the vector register readback block.
//   req_*  : request (valid/ready), base vreg, LMUL code, vl
//   rf_*   : synchronous element read port (data one cycle after rf_ren)
//   out_*  : element stream (valid/ready) with index and last flag
//   done/err : completion / rejection pulses
// Optional: out_sum exists only when RV32V_READBACK_CHECKSUM_EN is defined.
// modport slave = the readback block, modport master = its environment.
interface rv32v_vreg_readback_if #(
  parameter int VLENB  = 16,
  parameter int ELEM_W = 32
);
  localparam int EPR = VLENB * 8 / ELEM_W;
  localparam int EW  = (EPR > 1) ? $clog2(EPR) : 1;

  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_vreg;
  logic [1:0]        req_lmul;
  logic [7:0]        req_vl;
  logic              rf_ren;
  logic [4:0]        rf_sel;
  logic [EW-1:0]     rf_elem;
  logic [ELEM_W-1:0] rf_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;
  logic [7:0]        out_idx;
  logic              out_last;
  logic              done;
  logic              err;
`ifdef RV32V_READBACK_CHECKSUM_EN
  logic [ELEM_W-1:0] out_sum;
`endif

  modport slave (
`ifdef RV32V_READBACK_CHECKSUM_EN
    output out_sum,
`endif
    input  req_valid, req_vreg, req_lmul, req_vl, rf_rdata, out_ready,
    output req_ready, rf_ren, rf_sel, rf_elem,
    output out_valid, out_data, out_idx, out_last, done, err
  );

  modport master (
`ifdef RV32V_READBACK_CHECKSUM_EN
    input  out_sum,
`endif
    output req_valid, req_vreg, req_lmul, req_vl, rf_rdata, out_ready,
    input  req_ready, rf_ren, rf_sel, rf_elem,
    input  out_valid, out_data, out_idx, out_last, done, err
  );
endinterface

// File: rtl/rv32v_vreg_readback.sv
// rv32v_vreg_readback -- drains one LMUL register group of the rv32v vector
// register file, one ELEM_W element per cycle, onto a valid/ready stream.
// Ports:
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low reset (aborts any request, no done)
//   bus   : rv32v_vreg_readback_if.slave (req_*, rf_*, out_*, done, err)
// Optional feature macro RV32V_READBACK_CHECKSUM_EN: adds bus.out_sum, the
// modulo-2^ELEM_W sum of every beat transferred for the current request.
module rv32v_vreg_readback #(
  parameter int VLENB     = 16,
  parameter int ELEM_W    = 32,
  parameter int OUT_DEPTH = 2
) (
  input logic                     CLK,
  input logic                     nRST,
  rv32v_vreg_readback_if.slave    bus
);
  localparam int EPR = VLENB * 8 / ELEM_W;
  localparam int EW  = (EPR > 1) ? $clog2(EPR) : 1;
  localparam int ESH = $clog2(EPR);
  localparam int PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW  = $clog2(OUT_DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  typedef struct packed {
    logic [ELEM_W-1:0] data;
    logic [7:0]        idx;
    logic              last;
  } beat_t;

  logic [1:0]    r_state;
  logic [4:0]    r_vreg;
  logic [3:0]    r_g;
  logic [7:0]    r_n;
  logic [7:0]    r_k;
  logic          r_rd_vld;
  logic [7:0]    r_rd_idx;
  logic          r_rd_last;
  beat_t         r_buf [OUT_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic          r_err;

  logic [3:0]  w_g;
  logic [15:0] w_cap;
  logic [7:0]  w_vl_lim;
  logic        w_bad;
  logic        w_pop;
  logic        w_push;
  logic [CW:0] w_used;
  logic        w_ren;
  logic        w_k_last;
  logic        w_accept;
  beat_t       w_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_g      = 4'd1 << bus.req_lmul;
  assign w_cap    = 16'(EPR) << bus.req_lmul;
  // When vl exceeds the group capacity the capacity is at most 255, so the
  // truncation is exact.
  assign w_vl_lim = ({8'd0, bus.req_vl} < w_cap) ? bus.req_vl : w_cap[7:0];
  assign w_accept = (r_state == S_IDLE) && bus.req_valid;

  // Group must be aligned to its size and fit inside v0..v31.
  assign w_bad = ((r_vreg & (5'(r_g) - 5'd1)) != 5'd0) ||
                 (({1'b0, r_vreg} + {2'b00, r_g}) > 6'd32);

  assign w_head = r_buf[r_rptr];
  assign w_pop  = (r_cnt != '0) && bus.out_ready;
  assign w_push = r_rd_vld;

  // Credit counts the beat leaving this cycle, otherwise a depth-2 buffer
  // would only sustain one element every other cycle.
  assign w_used   = {1'b0, r_cnt} + {{CW{1'b0}}, r_rd_vld} - {{CW{1'b0}}, w_pop};
  assign w_ren    = (r_state == S_ISSUE) && (w_used < (CW+1)'(OUT_DEPTH));
  assign w_k_last = (r_k == r_n - 8'd1);

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rf_ren    = w_ren;
  assign bus.rf_sel    = r_vreg + 5'(r_k >> ESH);
  assign bus.rf_elem   = EW'(r_k & 8'(EPR - 1));
  assign bus.out_valid = (r_cnt != '0);
  assign bus.out_data  = w_head.data;
  assign bus.out_idx   = w_head.idx;
  assign bus.out_last  = w_head.last;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_vreg  <= '0;
      r_g     <= 4'd1;
      r_n     <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.req_valid) begin
          r_vreg  <= bus.req_vreg;
          r_g     <= w_g;
          r_n     <= w_vl_lim;
          r_k     <= '0;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_bad) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_n == 8'd0) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: if (w_ren) begin
          r_k <= r_k + 8'd1;
          if (w_k_last) r_state <= S_DRAIN;
        end
        S_DRAIN: if (w_pop && w_head.last) begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read-return tag: rides alongside the one-cycle register-file latency.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rd_vld  <= 1'b0;
      r_rd_idx  <= '0;
      r_rd_last <= 1'b0;
    end else begin
      r_rd_vld  <= w_ren;
      r_rd_idx  <= r_k;
      r_rd_last <= w_k_last;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < OUT_DEPTH; i++) r_buf[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_buf[r_wptr] <= '{data: bus.rf_rdata, idx: r_rd_idx, last: r_rd_last};
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

`ifdef RV32V_READBACK_CHECKSUM_EN
  logic [ELEM_W-1:0] r_sum;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)         r_sum <= '0;
    else if (w_accept) r_sum <= '0;
    else if (w_pop)    r_sum <= r_sum + w_head.data;
  end

  assign bus.out_sum = r_sum;
`endif

endmodule

// File: tb/tb_rv32v_vreg_readback.sv
module tb_rv32v_vreg_readback;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  rv32v_vreg_readback_if bus ();
  rv32v_vreg_readback dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  typedef struct {
    logic [31:0] data;
    logic [7:0]  idx;
    logic        last;
  } beat_t;

  typedef struct {
    logic [4:0] vreg;
    logic [1:0] lmul;
    logic [7:0] vl;
    int         ready_mode;   // 0: always ready, 1: 1,0,0,1 pattern
    logic       exp_err;
    int         exp_n;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [32][4];
  beat_t       sbq [$];
  int          cyc = 0;
  int          ready_mode = 0;
  int          ph = 0;

  // per-request observation state, written by the monitor
  int          cur_vreg, k_issue, ren_cnt, beats, first_cyc, last_cyc;
  int          done_cyc, ndone, acc_cyc, issued, popped;
  logic        done_err;
  logic [31:0] obs_sum;
  logic        prev_stall = 1'b0;
  logic [40:0] prev_beat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // register file: sample the strobe off-edge, present data for the next edge
  initial begin
    logic       p_ren;
    logic [4:0] p_sel;
    logic [1:0] p_elem;
    bus.rf_rdata = '0;
    forever begin
      @(negedge CLK);
      p_ren = bus.rf_ren; p_sel = bus.rf_sel; p_elem = bus.rf_elem;
      @(posedge CLK);
      #1;
      bus.rf_rdata = p_ren ? mem[p_sel][p_elem] : $urandom;
    end
  end

  // consumer back-pressure
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (ready_mode == 0) bus.out_ready = 1'b1;
      else                 bus.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
      ph++;
    end
  end

  always @(negedge CLK) begin
    if (nRST) begin
      if (bus.req_valid && bus.req_ready) acc_cyc = cyc + 1;
      if (prev_stall) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_beat", 64'({bus.out_data, bus.out_idx, bus.out_last}), 64'(prev_beat));
      end
      if (bus.rf_ren) begin
        chk("rf_sel", 64'(bus.rf_sel), 64'(cur_vreg + k_issue / 4));
        chk("rf_elem", 64'(bus.rf_elem), 64'(k_issue % 4));
        k_issue++; ren_cnt++; issued++;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("beat_expected", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          beat_t e;
          e = sbq.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e.data));
          chk("out_idx", 64'(bus.out_idx), 64'(e.idx));
          chk("out_last", 64'(bus.out_last), 64'(e.last));
        end
        if (beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++; popped++;
        obs_sum = obs_sum + bus.out_data;
      end
      if (bus.rf_ren) chk("outstanding_le2", 64'(issued - popped <= 2), 64'd1);
      if (bus.done) begin
        ndone++; done_cyc = cyc; done_err = bus.err;
      end else if (bus.err) begin
        chk("err_with_done", 64'(bus.done), 64'd1);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_beat  = {bus.out_data, bus.out_idx, bus.out_last};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_req(input vec_t v, output logic [31:0] s);
    s = '0;
    for (int k = 0; k < v.exp_n; k++) begin
      beat_t b;
      b.data = mem[int'(v.vreg) + k / 4][k % 4];
      b.idx  = 8'(k);
      b.last = (k == v.exp_n - 1);
      s      = s + b.data;
      sbq.push_back(b);
    end
    ready_mode = v.ready_mode;
    cur_vreg = v.vreg; k_issue = 0; ren_cnt = 0; beats = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1; ndone = 0;
    issued = 0; popped = 0; obs_sum = '0; done_err = 1'b0;
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b1; bus.req_vreg = v.vreg; bus.req_lmul = v.lmul; bus.req_vl = v.vl;
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0; bus.req_vreg = 5'(~v.vreg); bus.req_lmul = ~v.lmul;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [31:0] s;
    start_req(v, s);
    for (int i = 0; i < 400 && ndone == 0; i++) begin
      @(negedge CLK);
      #1;
    end
    chk($sformatf("v%0d_done_seen", id), 64'(ndone), 64'd1);
    chk($sformatf("v%0d_err", id), 64'(done_err), 64'(v.exp_err));
    repeat (3) @(negedge CLK);
    #1;
    chk($sformatf("v%0d_single_done", id), 64'(ndone), 64'd1);
    chk($sformatf("v%0d_beats", id), 64'(beats), 64'(v.exp_n));
    chk($sformatf("v%0d_reads", id), 64'(ren_cnt), 64'(v.exp_n));
    chk($sformatf("v%0d_sb_empty", id), 64'(sbq.size()), 64'd0);
    chk($sformatf("v%0d_req_ready", id), 64'(bus.req_ready), 64'd1);
    if (v.ready_mode == 0) begin
      if (v.exp_n == 0) begin
        chk($sformatf("v%0d_done_lat", id), 64'(done_cyc - acc_cyc), 64'd1);
      end else begin
        chk($sformatf("v%0d_first_lat", id), 64'(first_cyc - acc_cyc), 64'd3);
        chk($sformatf("v%0d_stream", id), 64'(last_cyc - first_cyc), 64'(v.exp_n - 1));
        chk($sformatf("v%0d_done_after_last", id), 64'(done_cyc - last_cyc), 64'd1);
      end
    end
`ifdef RV32V_READBACK_CHECKSUM_EN
    chk($sformatf("v%0d_sum", id), 64'(bus.out_sum), 64'(v.exp_err ? 32'd0 : s));
`endif
    sbq.delete();
  endtask

  vec_t vecs [12];

  initial begin
    logic [31:0] s;
    vecs[0]  = '{5'd1,  2'd0, 8'd4,   0, 1'b0, 4};
    vecs[1]  = '{5'd2,  2'd1, 8'd6,   0, 1'b0, 6};
    vecs[2]  = '{5'd2,  2'd1, 8'd20,  0, 1'b0, 8};
    vecs[3]  = '{5'd1,  2'd0, 8'd4,   1, 1'b0, 4};
    vecs[4]  = '{5'd3,  2'd1, 8'd4,   0, 1'b1, 0};
    vecs[5]  = '{5'd30, 2'd2, 8'd4,   0, 1'b1, 0};
    vecs[6]  = '{5'd5,  2'd0, 8'd0,   0, 1'b0, 0};
    vecs[7]  = '{5'd0,  2'd3, 8'd40,  1, 1'b0, 32};
    vecs[8]  = '{5'd24, 2'd3, 8'd5,   0, 1'b0, 5};
    vecs[9]  = '{5'd28, 2'd2, 8'd255, 0, 1'b0, 16};
    vecs[10] = '{5'd31, 2'd0, 8'd200, 0, 1'b0, 4};
    vecs[11] = '{5'd28, 2'd3, 8'd4,   0, 1'b1, 0};

    for (int r = 0; r < 32; r++)
      for (int e = 0; e < 4; e++)
        mem[r][e] = 32'hC000_005A | (32'(r) << 16) | (32'(e) << 8);
    for (int e = 0; e < 4; e++) begin
      mem[1][e] = 32'(e + 1);
      mem[2][e] = 32'(e);
      mem[3][e] = 32'(e + 4);
    end

    bus.req_valid = 1'b0; bus.req_vreg = '0; bus.req_lmul = '0; bus.req_vl = '0;
    #2;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rf_ren",    64'(bus.rf_ren),    64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_done",      64'(bus.done),      64'd0);
    chk("rst_err",       64'(bus.err),       64'd0);
    chk("rst_rf_addr",   64'({bus.rf_sel, bus.rf_elem}), 64'd0);
    chk("rst_out_beat",  64'({bus.out_data, bus.out_idx, bus.out_last}), 64'd0);
    repeat (3) @(posedge CLK);
    #1;
    nRST = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // reset in the middle of a request: stream aborts with no done pulse
    start_req(vecs[0], s);
    for (int i = 0; i < 100 && beats < 2; i++) begin
      @(negedge CLK);
      #1;
    end
    chk("mid_two_beats", 64'(beats), 64'd2);
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("mid_rst_rf_ren",    64'(bus.rf_ren),    64'd0);
    chk("mid_rst_done",      64'(bus.done),      64'd0);
    sbq.delete();
    repeat (3) @(posedge CLK);
    #1;
    nRST = 1'b1;
    repeat (4) @(negedge CLK);
    #1;
    chk("mid_rst_no_done", 64'(ndone), 64'd0);
    chk("mid_rst_no_valid", 64'(bus.out_valid), 64'd0);
    run_vec(vecs[0], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
